// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared CTRL register bit positions and address offsets for key_event_ctrl
package key_event_pkg;
  localparam int READY_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int OVR_BIT   = 2;
  localparam int IE_BIT    = 8;
  localparam int CNT_LSB   = 16;
  localparam int MASK_OFS  = 4;
endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - single-channel 2-flop synchroniser plus stability-counter debouncer
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic deb
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Reset loads the live input everywhere so release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= key;
      s2  <= key;
      deb <= key;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 != deb) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - debounced key input port with event FIFO, CTRL/status register and irq; KEY_EVENT_CTRL_EDGEMASK_EN adds a MASK register
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int               DBITS      = 32,
  parameter int               NKEYS      = 4,
  parameter int               DEPTH      = 4,
  parameter int               DEB_CYCLES = 16,
  parameter logic [DBITS-1:0] DATA_ADDR  = 32'hF000_0010,
  parameter logic [DBITS-1:0] CTRL_ADDR  = 32'hF000_0110
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [DBITS-1:0] dbus,
  input  logic [DBITS-1:0] address,
  input  logic             wrtEn,
  input  logic [NKEYS-1:0] keys,
  output logic             irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NKEYS-1:0] deb, prev;
  logic [NKEYS-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    count, count_nx;
  logic             ovr, ie, rd_data_q;
  logic             rd_data, rd_ctrl, wr_ctrl;
  logic             change, push, pop, pop_ok, push_ok, empty, full;
  logic             drive;
  logic [DBITS-1:0] rd_val, ctrl_word;
  logic             unused_bus;

  for (genvar i = 0; i < NKEYS; i++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .key   (keys[i]),
      .deb   (deb[i])
    );
  end

  assign rd_data = (address == DATA_ADDR) && !wrtEn;
  assign rd_ctrl = (address == CTRL_ADDR) && !wrtEn;
  assign wr_ctrl = (address == CTRL_ADDR) && wrtEn;
  assign change  = (deb != prev);

`ifdef KEY_EVENT_CTRL_EDGEMASK_EN
  logic [NKEYS-1:0] mask;
  logic             rd_mask, wr_mask;
  assign rd_mask = (address == CTRL_ADDR + DBITS'(MASK_OFS)) && !wrtEn;
  assign wr_mask = (address == CTRL_ADDR + DBITS'(MASK_OFS)) && wrtEn;
  assign push    = |((deb ^ prev) & mask);

  always_ff @(posedge clk) begin
    if (reset)        mask <= '1;
    else if (wr_mask) mask <= dbus[NKEYS-1:0];
  end
`else
  assign push = change;
`endif

  // A push into a full FIFO only lands when the same cycle also pops.
  always_comb begin
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    pop      = rd_data && !rd_data_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    count_nx = count + CW'(push_ok) - CW'(pop_ok);
  end

  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[READY_BIT]        = !empty;
    ctrl_word[FULL_BIT]         = full;
    ctrl_word[OVR_BIT]          = ovr;
    ctrl_word[IE_BIT]           = ie;
    ctrl_word[CNT_LSB +: CW]    = count;
  end

  always_comb begin
    drive  = 1'b0;
    rd_val = '0;
    if (rd_data) begin
      drive  = 1'b1;
      rd_val = DBITS'(empty ? deb : mem[rp]);
    end else if (rd_ctrl) begin
      drive  = 1'b1;
      rd_val = ctrl_word;
    end
`ifdef KEY_EVENT_CTRL_EDGEMASK_EN
    else if (rd_mask) begin
      drive  = 1'b1;
      rd_val = DBITS'(mask);
    end
`endif
  end

  assign dbus       = drive ? rd_val : {DBITS{1'bz}};
  assign unused_bus = ^dbus;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= deb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      ovr       <= 1'b0;
      ie        <= 1'b0;
      irq       <= 1'b0;
      rd_data_q <= 1'b0;
      prev      <= keys;
    end else begin
      rd_data_q <= rd_data;
      count     <= count_nx;
      irq       <= ie && (count_nx != '0);
      if (change)  prev <= deb;
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      // A dropped event in the same cycle as a clear keeps overrun set.
      if (push && full && !pop_ok)      ovr <= 1'b1;
      else if (wr_ctrl && !dbus[OVR_BIT]) ovr <= 1'b0;
      if (wr_ctrl) ie <= dbus[IE_BIT];
    end
  end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - self-checking bench for key_event_ctrl with an event scoreboard queue
module tb_key_event_ctrl;
  localparam int          DBITS     = 32;
  localparam int          NKEYS     = 4;
  localparam int          DEPTH     = 4;
  localparam int          DEB       = 16;
  localparam logic [31:0] DATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] CTRL_ADDR = 32'hF000_0110;
  localparam logic [31:0] MASK_ADDR = 32'hF000_0114;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [DBITS-1:0]  address;
  logic              wrtEn;
  logic [NKEYS-1:0]  keys;
  wire  [DBITS-1:0]  dbus;
  logic              irq;
  logic              tb_drv;
  logic [DBITS-1:0]  tb_val;

  int               checks = 0;
  int               errors = 0;
  logic [NKEYS-1:0] q[$];
  logic             m_ovr;
  logic             m_ie;
  logic [NKEYS-1:0] m_deb;

  typedef struct {
    logic [NKEYS-1:0] k;
    logic [4:0]       exp_cnt;
    logic             exp_ovr;
  } vec_t;
  vec_t tbl[5];

  assign dbus = tb_drv ? tb_val : {DBITS{1'bz}};
  always #5 clk = ~clk;

  key_event_ctrl #(
    .DBITS(DBITS), .NKEYS(NKEYS), .DEPTH(DEPTH), .DEB_CYCLES(DEB),
    .DATA_ADDR(DATA_ADDR), .CTRL_ADDR(CTRL_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .dbus(dbus), .address(address),
    .wrtEn(wrtEn), .keys(keys), .irq(irq)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_exp();
    logic [31:0] w;
    w        = '0;
    w[0]     = (q.size() != 0);
    w[1]     = (q.size() == DEPTH);
    w[2]     = m_ovr;
    w[8]     = m_ie;
    w[20:16] = 5'(q.size());
    return w;
  endfunction

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    address = a;
    wrtEn   = 1'b0;
    #1;
    d = dbus;
    @(posedge clk);
    #1;
    address = IDLE_ADDR;
    tick(1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    address = a;
    wrtEn   = 1'b1;
    tb_val  = v;
    tb_drv  = 1'b1;
    @(posedge clk);
    #1;
    tb_drv  = 1'b0;
    wrtEn   = 1'b0;
    address = IDLE_ADDR;
    tick(1);
  endtask

  task automatic expect_data(input string name);
    logic [31:0] d;
    logic [31:0] e;
    rd(DATA_ADDR, d);
    e = (q.size() != 0) ? 32'(q.pop_front()) : 32'(m_deb);
    check(name, d, e);
  endtask

  task automatic expect_ctrl(input string name);
    logic [31:0] d;
    rd(CTRL_ADDR, d);
    check(name, d, ctrl_exp());
  endtask

  task automatic event_keys(input logic [NKEYS-1:0] v);
    keys  = v;
    m_deb = v;
    if (q.size() < DEPTH) q.push_back(v);
    else m_ovr = 1'b1;
    tick(DEB + 8);
  endtask

  initial begin
    logic [31:0] d;
    int          first;

    tbl[0] = '{4'hC, 5'd1, 1'b0};
    tbl[1] = '{4'h8, 5'd2, 1'b0};
    tbl[2] = '{4'h0, 5'd3, 1'b0};
    tbl[3] = '{4'h1, 5'd4, 1'b0};
    tbl[4] = '{4'h3, 5'd4, 1'b1};

    reset = 1'b1; address = IDLE_ADDR; wrtEn = 1'b0; keys = 4'hF;
    tb_drv = 1'b0; tb_val = '0; m_ovr = 1'b0; m_ie = 1'b0; m_deb = 4'hF;
    tick(2);
    reset = 1'b0;
    tick(40);
    check("reset_irq", 32'(irq), 32'h0);
    expect_ctrl("reset_ctrl");
    expect_data("reset_data_debounced");
    expect_ctrl("empty_pop_noeffect");

    // short glitch must not reach the debounced vector
    keys = 4'hE;
    tick(5);
    keys = 4'hF;
    tick(30);
    expect_ctrl("glitch_no_event");

    keys  = 4'hE;
    m_deb = 4'hE;
    first = 0;
    address = CTRL_ADDR;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (first == 0 && dbus[0]) first = e;
    end
    address = IDLE_ADDR;
    tick(1);
    q.push_back(4'hE);
    check("ready_latency_window", 32'(first >= 18 && first <= 19), 32'h1);
    expect_data("first_event_data");
    expect_ctrl("after_pop_ctrl");

    for (int i = 0; i < 5; i++) begin
      logic [31:0] w;
      event_keys(tbl[i].k);
      rd(CTRL_ADDR, d);
      w        = '0;
      w[0]     = (tbl[i].exp_cnt != 0);
      w[1]     = (tbl[i].exp_cnt == 5'(DEPTH));
      w[2]     = tbl[i].exp_ovr;
      w[20:16] = tbl[i].exp_cnt;
      check($sformatf("fill_ctrl_%0d", i), d, w);
    end
    for (int i = 0; i < DEPTH; i++) expect_data($sformatf("drain_%0d", i));
    expect_ctrl("drained_ovr_kept");
    expect_data("empty_read_debounced");
    wr(CTRL_ADDR, 32'h0);
    m_ovr = 1'b0;
    expect_ctrl("ovr_cleared");

    wr(CTRL_ADDR, 32'h0000_0104);
    m_ie = 1'b1;
    expect_ctrl("ie_set");
    keys  = 4'h7;
    m_deb = 4'h7;
    first = 0;
    for (int e = 1; e <= 30; e++) begin
      tick(1);
      if (first == 0 && irq) first = e;
    end
    q.push_back(4'h7);
    check("irq_latency_window", 32'(first >= 18 && first <= 20), 32'h1);
    event_keys(4'hF);
    expect_ctrl("two_events_ie");

    // a read held for three cycles pops exactly once
    address = DATA_ADDR;
    #1;
    check("held_read_data", dbus, 32'(q.pop_front()));
    tick(3);
    address = IDLE_ADDR;
    tick(1);
    expect_ctrl("held_read_single_pop");
    check("irq_still_pending", 32'(irq), 32'h1);
    expect_data("last_event_data");
    check("irq_dropped", 32'(irq), 32'h0);
    wr(CTRL_ADDR, 32'h0);
    m_ie = 1'b0;

`ifdef KEY_EVENT_CTRL_EDGEMASK_EN
    wr(MASK_ADDR, 32'h1);
    rd(MASK_ADDR, d);
    check("mask_readback", d, 32'h1);
    keys  = 4'hD;
    m_deb = 4'hD;
    tick(DEB + 8);
    expect_ctrl("masked_no_event");
    event_keys(4'hC);
    expect_data("masked_event_snapshot");
    wr(MASK_ADDR, 32'hF);
`endif

    event_keys(4'h6);
    event_keys(4'h2);
    event_keys(4'hA);
    event_keys(4'h8);
    expect_ctrl("refill_full");
    // push lands on the same edge as the pop of a full FIFO
    keys  = 4'h9;
    m_deb = 4'h9;
    tick(DEB + 2);
    rd(DATA_ADDR, d);
    check("full_push_pop_data", d, 32'(q.pop_front()));
    q.push_back(4'h9);
    tick(5);
    expect_ctrl("full_push_pop_ctrl");

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    m_ie  = 1'b0;
    tick(2);
    check("midrun_reset_irq", 32'(irq), 32'h0);
    expect_ctrl("midrun_reset_ctrl");
    expect_data("midrun_reset_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
